// File: rtl/sr_drive_pkg.sv
// sr_drive_pkg: shared FSM states, SR excitation codes and width helper for sr_drive_ctrl.
package sr_drive_pkg;
  typedef enum logic [1:0] {IDLE, DRIVE, SETTLE, CHECK} state_t;
  localparam logic [1:0] EXC_HOLD = 2'b00;
  localparam logic [1:0] EXC_RST  = 2'b01;
  localparam logic [1:0] EXC_SET  = 2'b10;
  localparam logic [1:0] EXC_BAD  = 2'b11;
  function automatic int cw(input int n);
    return n > 0 ? $clog2(n + 1) : 1;
  endfunction
endpackage

// File: rtl/sr_excite_enc.sv
// sr_excite_enc: per-bit SR excitation {S,R} that moves fb towards tgt; never emits EXC_BAD.
module sr_excite_enc
  import sr_drive_pkg::*;
(
  input  logic       tgt,
  input  logic       fb,
  output logic [1:0] code
);
  assign code = tgt == fb ? EXC_HOLD : (tgt ? EXC_SET : EXC_RST);
endmodule

// File: rtl/sr_drive_ctrl.sv
// sr_drive_ctrl: drives a one-cycle S/R command into an SR flip-flop bank and verifies readback.
// Define SR_DRIVE_RETRY_EN to re-drive mismatched bits up to MAX_RETRY times before err.
module sr_drive_ctrl
  import sr_drive_pkg::*;
#(
  parameter int WIDTH      = 4,
  parameter int SETTLE_CYC = 1,
  parameter int MAX_RETRY  = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             tgt_valid,
  input  logic [WIDTH-1:0] tgt_data,
  output logic             tgt_ready,
  input  logic [WIDTH-1:0] q_fb,
  output logic [WIDTH-1:0] s_out,
  output logic [WIDTH-1:0] r_out,
  output logic             done,
  output logic             err,
  output logic [WIDTH-1:0] mism
);
  localparam int CW = cw(SETTLE_CYC);
  if (WIDTH < 1 || SETTLE_CYC < 0 || MAX_RETRY < 0) begin : g_bad_param
    $error("sr_drive_ctrl: illegal parameter value");
  end
  state_t           state;
  logic [WIDTH-1:0] tgt_q, enc_tgt, s_nxt, r_nxt, diff;
  logic [CW-1:0]    cnt;
  logic             accept, retry_go;
  assign accept  = state == IDLE && tgt_valid && tgt_ready;
  // Encoders see the fresh target at accept and the latched one when re-driving.
  assign enc_tgt = state == IDLE ? tgt_data : tgt_q;
  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    logic [1:0] code;
    sr_excite_enc u_enc (.tgt(enc_tgt[i]), .fb(q_fb[i]), .code(code));
    assign {s_nxt[i], r_nxt[i]} = code;
    assign diff[i] = q_fb[i] === tgt_q[i] ? 1'b0 : 1'b1;
    assert property (@(posedge clk) {s_out[i], r_out[i]} != EXC_BAD);
  end
  assert property (@(posedge clk) !(done && err));
`ifdef SR_DRIVE_RETRY_EN
  localparam int RW = cw(MAX_RETRY);
  logic [RW-1:0] retry;
  assign retry_go = retry < RW'(MAX_RETRY);
  always_ff @(posedge clk)
    if (!reset || accept) retry <= '0;
    else if (state == CHECK && diff != '0 && retry_go) retry <= retry + 1'b1;
`else
  assign retry_go = 1'b0;
`endif
  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= IDLE;
      tgt_ready <= 1'b0;
      s_out     <= '0;
      r_out     <= '0;
      done      <= 1'b0;
      err       <= 1'b0;
      mism      <= '0;
      tgt_q     <= '0;
      cnt       <= '0;
    end else begin
      s_out <= '0;
      r_out <= '0;
      done  <= 1'b0;
      err   <= 1'b0;
      case (state)
        IDLE: begin
          tgt_ready <= !accept;
          if (accept) begin
            tgt_q <= tgt_data;
            mism  <= '0;
            s_out <= s_nxt;
            r_out <= r_nxt;
            state <= (s_nxt | r_nxt) != '0 ? DRIVE : CHECK;
          end
        end
        DRIVE: begin
          state <= SETTLE_CYC > 0 ? SETTLE : CHECK;
          cnt   <= CW'(SETTLE_CYC > 0 ? SETTLE_CYC - 1 : 0);
        end
        SETTLE: begin
          state <= cnt == '0 ? CHECK : SETTLE;
          cnt   <= cnt - 1'b1;
        end
        CHECK: begin
          mism <= diff;
          if (diff != '0 && retry_go) begin
            state <= DRIVE;
            s_out <= s_nxt;
            r_out <= r_nxt;
          end else begin
            state     <= IDLE;
            tgt_ready <= 1'b1;
            done      <= diff == '0;
            err       <= diff != '0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: doc/sr_drive_ctrl.md
Name: sr_drive_ctrl

Overview:
- Initiator side of the SR flip-flop command interface: accepts a target state vector over valid/ready, encodes per-bit S/R excitation against the current flip-flop outputs, and drives a one-cycle command pulse into a bank of WIDTH SR flip-flops.
- Waits a settle interval, reads the bank back and reports done or mismatch.
- Guarantees the bank never sees the illegal S=R=1 code.

Parameters:
WIDTH, 4, number of SR flip-flops in the driven bank
SETTLE_CYC, 1, cycles between the command pulse and readback compare (0 allowed)
MAX_RETRY, 2, re-drive attempts after mismatch (used only with SR_DRIVE_RETRY_EN)

Ports:
clk  input  1  rising-edge clock
reset  input  1  synchronous, active-low reset
tgt_valid  input  1  target vector offered
tgt_data  input  WIDTH  desired flip-flop state
tgt_ready  output  1  block can accept a target
q_fb  input  WIDTH  Q outputs of the driven SR flip-flop bank
s_out  output  WIDTH  S commands to the bank
r_out  output  WIDTH  R commands to the bank
done  output  1  one-cycle pulse: bank matches target
err  output  1  one-cycle pulse: bank mismatch after final attempt
mism  output  WIDTH  per-bit mismatch mask, valid with done/err, held until next accept

Behaviour:
- Reset (reset==0 at posedge) forces the following, regardless of state, including mid-operation:
  - state IDLE
  - s_out=0, r_out=0, done=0, err=0, mism=0
  - latched target=0, retry count=0
  - tgt_ready=0 during the reset cycle
- FSM states: IDLE, DRIVE, SETTLE, CHECK.
- IDLE:
  - tgt_ready=1.
  - On tgt_valid && tgt_ready, latch tgt_data as tgt_q.
  - Compute per-bit excitation from tgt_data and q_fb sampled in that same cycle: target 1 / fb 0 gives S=1 R=0; target 0 / fb 1 gives S=0 R=1; equal gives 00.
  - Register the excitation into s_out/r_out.
  - Go to DRIVE, or directly to CHECK if no bit differs; s_out/r_out stay 0 in that case.
- DRIVE:
  - s_out/r_out held exactly one cycle, then cleared to 0.
  - Next state is SETTLE if SETTLE_CYC>0, else CHECK.
- SETTLE:
  - Down-counter loaded with SETTLE_CYC-1.
  - Exit to CHECK when the counter is 0.
  - Counter width is clog2(SETTLE_CYC+1), minimum 1.
- CHECK:
  - mism = tgt_q ^ q_fb.
  - mism==0: pulse done and go to IDLE.
  - mism!=0: pulse err and go to IDLE; with retry enabled, see Optional Feature.
  - Any X/Z on q_fb counts as mismatch on that bit.
- Latency from accept: DRIVE at cycle +1, CHECK at cycle +2+SETTLE_CYC, done/err registered one cycle after CHECK.
- No-change target: CHECK at cycle +1, done at cycle +2.
- Invariant: (s_out & r_out)==0 every cycle. s_out/r_out are nonzero only in DRIVE.
- tgt_ready=0 in all states except IDLE; tgt_valid there is ignored and not lost (upstream holds it).
- done and err are never high together.
- tgt_data changing after accept has no effect.
- q_fb is sampled only at accept and in CHECK.

Optional Feature:
Macro SR_DRIVE_RETRY_EN.
- Defined:
  - On mismatch in CHECK with retry count < MAX_RETRY, increment the count and go back to DRIVE.
  - The new excitation is recomputed from tgt_q vs q_fb at CHECK, covering mismatched bits only.
  - err pulses only when the count == MAX_RETRY.
  - The count clears on accept.
- Undefined:
  - No retry counter logic is synthesised.
  - First mismatch gives an immediate err; MAX_RETRY is ignored.

Decomposition:
- Package sr_drive_pkg:
  - state enum typedef (IDLE, DRIVE, SETTLE, CHECK)
  - 2-bit excitation code constants EXC_HOLD=2'b00, EXC_RST=2'b01, EXC_SET=2'b10
  - illegal code constant EXC_BAD=2'b11, used only by assertions
- Sub-module sr_excite_enc: purely combinational per-bit encoder (target, fb) -> {S,R}, instantiated WIDTH times via generate. Reused by the retry path.

Test Plan:
- Reset low mid-SETTLE with s_out=4'b0101 just driven -> next cycle all outputs 0, tgt_ready=0; after reset=1, tgt_ready=1 and no done/err.
- Bank model at q_fb=4'b0000, accept tgt_data=4'b1010 -> DRIVE cycle s_out=4'b1010, r_out=0; model updates; done pulse at accept+4 (SETTLE_CYC=1), mism=0.
- q_fb=4'b1111, accept 4'b0110 -> r_out=4'b1001, s_out=0 for exactly one cycle; done; s_out&r_out==0 asserted throughout.
- q_fb=4'b0011, accept 4'b0011 -> no DRIVE, s_out=r_out=0, done at accept+2.
- Stuck-at-0 on bit 2, target 4'b0100, macro undefined -> err pulse, mism=4'b0100, done never asserted.
- Same stuck bit, SR_DRIVE_RETRY_EN defined, MAX_RETRY=2 -> three DRIVE pulses with s_out=4'b0100 each, single err after the third CHECK. Releasing the fault before the second retry -> done, no err.
